fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 stall  input  1  decode stage cannot accept; hold output.
REQ-005 redirect_valid  input  1  branch/jump/exception redirect this cycle.
REQ-006 redirect_pc  input  32  redirect target (word_t).
REQ-007 inst_req  output  1  instruction-memory request.
REQ-008 inst_addr  output  32  request address.
REQ-009 inst_addr_ok  input  1  address accepted this cycle.
REQ-010 inst_data_ok  input  1  read data valid this cycle.
REQ-011 inst_rdata  input  32  read data.
REQ-012 out_valid  output  1  fetched instruction presented to decode.
REQ-013 out_pc / out_instr / out_pcplus4  output  32 each  PC, instruction, PC+4 of presented instruction.
REQ-014 out_adel  output  1  misaligned fetch flag (REQ-031 only; else tied 0).

Function
REQ-015 States: REQ (inst_req=1, inst_addr=pc held stable), WAIT (one request outstanding, inst_req=0), HOLD (response captured, stalled).
REQ-016 REQ->WAIT on inst_addr_ok; WAIT->REQ on inst_data_ok when not stalled and not discarding; WAIT->HOLD on inst_data_ok with stall=1; HOLD->REQ when stall=0.
REQ-017 At most one outstanding request; inst_req never asserted in WAIT or HOLD.
REQ-018 inst_addr shall not change while inst_req=1 and inst_addr_ok=0, even on redirect.
REQ-019 On accepted data (not discarded) register out_instr=inst_rdata, out_pc=request pc, out_pcplus4=pc+4 (mod 2^32, wraps); out_valid=1 next cycle.
REQ-020 Minimum latency: addr_ok in cycle N, data_ok in N+1 -> out_valid in N+2.
REQ-021 Next pc = pc+4 after a non-discarded response; redirect_pc on redirect.
REQ-022 While stall=1, out_* held unchanged; when stall=0 and no new data, out_valid drops to 0 next cycle.
REQ-023 Redirect in REQ before addr_ok: latch redirect_pc as pending target; mark the eventual response as discard.
REQ-024 Redirect in WAIT: set discard; on data_ok drop data, go to REQ at redirect_pc.
REQ-025 Redirect in HOLD: clear out_valid, go to REQ at redirect_pc next cycle.
REQ-026 Redirect overrides stall; output invalidated same-edge.
REQ-027 Redirect coincident with data_ok in WAIT: response discarded.
REQ-028 Second redirect while one pending: later target wins.

Reset
REQ-029 On reset: state=REQ, pc=RESET_PC, discard=0, pending=0, out_valid=0, out_pc/out_instr/out_pcplus4=0, out_adel=0.
REQ-030 Reset mid-request abandons outstanding transaction; a data_ok arriving after reset release with state REQ is ignored.

Configuration
REQ-031 Macro FETCH_ADEL_CHECK_EN: defined -> pc[1:0]!=0 raises no inst_req, presents out_valid=1, out_adel=1, out_instr=0 next cycle, then waits for redirect; undefined -> out_adel=0, pc[1:0] forced to 0 on inst_addr.

Structure
REQ-032 word_t, fetch_state_t enum and RESET_PC default live in the shared global package.
REQ-033 One sub-module fetch_buf: one-entry output register holding pc/instr/pcplus4/adel with load/hold/clear controls.

Verification
REQ-034 Reset release, memory with addr_ok=1, data_ok next cycle -> inst_addr 0xBFC00000, 0xBFC00004, 0xBFC00008; out_pcplus4 0xBFC00004 for first.
REQ-035 stall=1 for 3 cycles while out_pc=0xBFC00004 -> outputs unchanged, inst_req=0 after HOLD; resume at 0xBFC00008.
REQ-036 redirect 0x80001000 in WAIT, data_ok 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never valid; next inst_addr=0x80001000.
REQ-037 addr_ok held 0 for 4 cycles with redirect on cycle 2 -> inst_addr stays 0xBFC00000 until accepted, response discarded, then 0x80001000.
REQ-038 With FETCH_ADEL_CHECK_EN, redirect to 0x80000002 -> no inst_req, out_adel=1, out_pc=0x80000002.
REQ-039 reset asserted in WAIT, late data_ok after release -> out_valid stays 0; first request at 0xBFC00000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Optional feature macro: FETCH_ADEL_CHECK_EN (misaligned-fetch trap).
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Word-align an address by clearing the byte-offset bits.
    function automatic word_t align_pc(input word_t pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_buf.sv
// One-entry output register between fetch and decode.
// Holds pc / instr / pc+4 / adel; clear has priority over load.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        adel_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        adel_o
);

    logic  valid_q;
    logic  adel_q;
    word_t pc_q;
    word_t instr_q;
    word_t pcplus4_q;

    // Capture a new entry, invalidate it, or hold it unchanged.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q   <= 1'b0;
            adel_q    <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            pcplus4_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            adel_q    <= adel_i;
            pc_q      <= pc_i;
            instr_q   <= instr_i;
            pcplus4_q <= pc_i + 32'd4;
        end
    end

    assign valid_o   = valid_q;
    assign adel_o    = adel_q;
    assign pc_o      = pc_q;
    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request to instruction memory,
// redirect handling with response discard, one-entry output register.
// Optional feature macro: FETCH_ADEL_CHECK_EN -- when defined, a misaligned
// pc raises no request and presents an address-error entry instead; when
// undefined, the byte-offset bits are simply cleared on inst_addr_o.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        out_valid_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pcplus4_o,
    output logic        out_adel_o
);

    fetch_state_t state_q;
    word_t        pc_q;
    word_t        pend_pc_q;
    logic         discard_q;
    logic         pending_q;

    logic  buf_valid;
    logic  buf_adel;
    logic  buf_load;
    logic  buf_clear;
    logic  buf_adel_in;
    word_t buf_instr_in;
    logic  misaligned;
    logic  stall_block;

`ifdef FETCH_ADEL_CHECK_EN
    assign misaligned  = (pc_q[1:0] != 2'b00);
    assign inst_addr_o = pc_q;
`else
    assign misaligned  = 1'b0;
    assign inst_addr_o = align_pc(pc_q);
`endif

    // A new request is held back only while an unconsumed entry sits in the
    // output register under stall; otherwise a second response would have
    // nowhere to land. Once issued, the request stays up until accepted.
    assign stall_block = buf_valid && stall_i;
    assign inst_req_o  = (state_q == S_REQ) && !stall_block && !misaligned;

    // Output-register control: redirect invalidates, a good response or an
    // address-error entry loads, otherwise an unstalled decode consumes it.
    always_comb begin
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        buf_instr_in = inst_rdata_i;
        buf_adel_in  = 1'b0;
        if (redirect_valid_i) begin
            buf_clear = 1'b1;
        end else begin
            if (state_q == S_WAIT && inst_data_ok_i && !discard_q) begin
                buf_load = 1'b1;
            end
            if (state_q == S_REQ && misaligned && !stall_block) begin
                buf_load     = 1'b1;
                buf_instr_in = '0;
                buf_adel_in  = 1'b1;
            end
            if (!buf_load && !stall_i) begin
                buf_clear = 1'b1;
            end
        end
    end

    // Fetch sequencing: request, wait for data, hold while decode is stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            discard_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (inst_req_o) begin
                        // Address must stay put until accepted; remember the
                        // redirect and throw away the old response later.
                        if (redirect_valid_i) begin
                            pending_q <= 1'b1;
                            pend_pc_q <= redirect_pc_i;
                            discard_q <= 1'b1;
                        end
                        if (inst_addr_ok_i) begin
                            state_q <= S_WAIT;
                        end
                    end else if (redirect_valid_i) begin
                        pc_q      <= redirect_pc_i;
                        pending_q <= 1'b0;
                        discard_q <= 1'b0;
                    end else if (misaligned && !stall_block) begin
                        state_q <= S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok_i) begin
                        if (redirect_valid_i) begin
                            pc_q      <= redirect_pc_i;
                            pending_q <= 1'b0;
                            discard_q <= 1'b0;
                            state_q   <= S_REQ;
                        end else if (discard_q) begin
                            pc_q      <= pending_q ? pend_pc_q : pc_q;
                            pending_q <= 1'b0;
                            discard_q <= 1'b0;
                            state_q   <= S_REQ;
                        end else begin
                            pc_q    <= pc_q + 32'd4;
                            state_q <= stall_i ? S_HOLD : S_REQ;
                        end
                    end else if (redirect_valid_i) begin
                        pending_q <= 1'b1;
                        pend_pc_q <= redirect_pc_i;
                        discard_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // An address-error entry parks here until redirected.
                    if (redirect_valid_i) begin
                        pc_q    <= redirect_pc_i;
                        state_q <= S_REQ;
                    end else if (!stall_i && !buf_adel) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    fetch_buf u_buf (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (buf_load),
        .clear_i   (buf_clear),
        .pc_i      (pc_q),
        .instr_i   (buf_instr_in),
        .adel_i    (buf_adel_in),
        .valid_o   (buf_valid),
        .pc_o      (out_pc_o),
        .instr_o   (out_instr_o),
        .pcplus4_o (out_pcplus4_o),
        .adel_o    (buf_adel)
    );

    assign out_valid_o = buf_valid;
    assign out_adel_o  = buf_adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/hold, redirects in
// each state, address hold before accept, pc wrap, misalignment, reset.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pcplus4_o;
    logic        out_adel_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_req_o       (inst_req_o),
        .inst_addr_o      (inst_addr_o),
        .inst_addr_ok_i   (inst_addr_ok_i),
        .inst_data_ok_i   (inst_data_ok_i),
        .inst_rdata_i     (inst_rdata_i),
        .out_valid_o      (out_valid_o),
        .out_pc_o         (out_pc_o),
        .out_instr_o      (out_instr_o),
        .out_pcplus4_o    (out_pcplus4_o),
        .out_adel_o       (out_adel_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge, then clear the strobes.
    task automatic tick();
        @(posedge clk_i);
        #1;
        redirect_valid_i = 1'b0;
        inst_addr_ok_i   = 1'b0;
        inst_data_ok_i   = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%b exp=0", out_valid_o); end
        n_checks++; if (out_pc_o !== 32'h0 || out_instr_o !== 32'h0 || out_pcplus4_o !== 32'h0) begin n_errors++; $display("FAIL rst_out got=%h/%h/%h exp=0/0/0", out_pc_o, out_instr_o, out_pcplus4_o); end
        n_checks++; if (out_adel_o !== 1'b0) begin n_errors++; $display("FAIL rst_adel got=%b exp=0", out_adel_o); end
        n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL rst_req got=%b/%h exp=1/bfc00000", inst_req_o, inst_addr_o); end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    // Back-to-back fetch, then a 3-cycle stall on the second instruction.
    task automatic test_sequential_stall();
        inst_addr_ok_i = 1'b1; #2;
        n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL seq_a0 got=%b/%h exp=1/bfc00000", inst_req_o, inst_addr_o); end
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h11110000; #2;
        n_checks++; if (inst_req_o !== 1'b0) begin n_errors++; $display("FAIL seq_wait_req got=%b exp=0", inst_req_o); end
        tick();
        inst_addr_ok_i = 1'b1; #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'hBFC00000 || out_instr_o !== 32'h11110000) begin n_errors++; $display("FAIL seq_out0 got=%b/%h/%h exp=1/bfc00000/11110000", out_valid_o, out_pc_o, out_instr_o); end
        n_checks++; if (out_pcplus4_o !== 32'hBFC00004) begin n_errors++; $display("FAIL seq_pc4_0 got=%h exp=bfc00004", out_pcplus4_o); end
        n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC00004) begin n_errors++; $display("FAIL seq_a1 got=%b/%h exp=1/bfc00004", inst_req_o, inst_addr_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL seq_drop got=%b exp=0", out_valid_o); end
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h22220000; stall_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            stall_i = 1'b1; #2;
            n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'hBFC00004 || out_instr_o !== 32'h22220000 || out_pcplus4_o !== 32'hBFC00008) begin n_errors++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=1/bfc00004/22220000/bfc00008", i, out_valid_o, out_pc_o, out_instr_o, out_pcplus4_o); end
            n_checks++; if (inst_req_o !== 1'b0) begin n_errors++; $display("FAIL stall_req%0d got=%b exp=0", i, inst_req_o); end
            tick();
        end
        stall_i = 1'b0; #2;
        n_checks++; if (out_valid_o !== 1'b1 || inst_req_o !== 1'b0) begin n_errors++; $display("FAIL stall_release got=%b/%b exp=1/0", out_valid_o, inst_req_o); end
        tick();
        inst_addr_ok_i = 1'b1; #2;
        n_checks++; if (out_valid_o !== 1'b0 || inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC00008) begin n_errors++; $display("FAIL resume got=%b/%b/%h exp=0/1/bfc00008", out_valid_o, inst_req_o, inst_addr_o); end
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h33330000;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'hBFC00008 || out_pcplus4_o !== 32'hBFC0000C) begin n_errors++; $display("FAIL seq_out2 got=%b/%h/%h exp=1/bfc00008/bfc0000c", out_valid_o, out_pc_o, out_pcplus4_o); end
        n_checks++; if (inst_addr_o !== 32'hBFC0000C) begin n_errors++; $display("FAIL seq_a3 got=%h exp=bfc0000c", inst_addr_o); end
    endtask

    // Redirect while waiting; late bad data must never be presented.
    task automatic test_redirect_wait();
        inst_addr_ok_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80001000;
        tick();
        #2;
        n_checks++; if (inst_req_o !== 1'b0 || out_valid_o !== 1'b0) begin n_errors++; $display("FAIL rw_wait got=%b/%b exp=0/0", inst_req_o, out_valid_o); end
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEADBEEF;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL rw_discard got=%b instr=%h exp=0", out_valid_o, out_instr_o); end
        n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h80001000) begin n_errors++; $display("FAIL rw_target got=%b/%h exp=1/80001000", inst_req_o, inst_addr_o); end
        inst_addr_ok_i = 1'b1;
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h44440000;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h80001000 || out_instr_o !== 32'h44440000 || out_pcplus4_o !== 32'h80001004) begin n_errors++; $display("FAIL rw_fetch got=%b/%h/%h/%h exp=1/80001000/44440000/80001004", out_valid_o, out_pc_o, out_instr_o, out_pcplus4_o); end
    endtask

    // addr_ok withheld 4 cycles with a redirect in the second: address holds.
    task automatic test_addr_hold();
        reset_i = 1'b1; #2; reset_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin redirect_valid_i = 1'b1; redirect_pc_i = 32'h80001000; end
            #2;
            n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL ah_hold%0d got=%b/%h exp=1/bfc00000", i, inst_req_o, inst_addr_o); end
            tick();
        end
        inst_addr_ok_i = 1'b1; #2;
        n_checks++; if (inst_addr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL ah_accept got=%h exp=bfc00000", inst_addr_o); end
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hCAFEF00D;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b0 || inst_addr_o !== 32'h80001000 || inst_req_o !== 1'b1) begin n_errors++; $display("FAIL ah_after got=%b/%h/%b exp=0/80001000/1", out_valid_o, inst_addr_o, inst_req_o); end
    endtask

    // Redirect coincident with data_ok, and two redirects while pending.
    task automatic test_redirect_races();
        inst_addr_ok_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80002000;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80003000;
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBAD00001;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b0 || inst_addr_o !== 32'h80003000) begin n_errors++; $display("FAIL coinc got=%b/%h exp=0/80003000", out_valid_o, inst_addr_o); end
        inst_addr_ok_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80004000;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80005000;
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBAD00002;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b0 || inst_addr_o !== 32'h80005000) begin n_errors++; $display("FAIL later_wins got=%b/%h exp=0/80005000", out_valid_o, inst_addr_o); end
    endtask

    // Redirect during HOLD overrides stall and invalidates the same edge.
    task automatic test_hold_redirect();
        inst_addr_ok_i = 1'b1;
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h55550000; stall_i = 1'b1;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h80005000) begin n_errors++; $display("FAIL hr_hold got=%b/%h exp=1/80005000", out_valid_o, out_pc_o); end
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80006000;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b0 || inst_req_o !== 1'b1 || inst_addr_o !== 32'h80006000) begin n_errors++; $display("FAIL hr_redirect got=%b/%b/%h exp=0/1/80006000", out_valid_o, inst_req_o, inst_addr_o); end
        stall_i = 1'b0;
    endtask

    // pc+4 wraps modulo 2^32 at the top of the address space.
    task automatic test_wrap();
        inst_addr_ok_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBAD00003;
        tick();
        inst_addr_ok_i = 1'b1; #2;
        n_checks++; if (inst_addr_o !== 32'hFFFFFFFC) begin n_errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", inst_addr_o); end
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h12345678;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'hFFFFFFFC || out_pcplus4_o !== 32'h00000000 || out_instr_o !== 32'h12345678) begin n_errors++; $display("FAIL wrap_out got=%b/%h/%h/%h exp=1/fffffffc/00000000/12345678", out_valid_o, out_pc_o, out_pcplus4_o, out_instr_o); end
        n_checks++; if (inst_addr_o !== 32'h00000000) begin n_errors++; $display("FAIL wrap_next got=%h exp=00000000", inst_addr_o); end
    endtask

    // Redirect to a misaligned target.
    task automatic test_misaligned();
        inst_addr_ok_i = 1'b1;
        tick();
        inst_data_ok_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h80000002;
        tick();
        #2;
`ifdef FETCH_ADEL_CHECK_EN
        n_checks++; if (inst_req_o !== 1'b0) begin n_errors++; $display("FAIL adel_noreq got=%b exp=0", inst_req_o); end
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_adel_o !== 1'b1 || out_pc_o !== 32'h80000002 || out_instr_o !== 32'h0) begin n_errors++; $display("FAIL adel_out got=%b/%b/%h/%h exp=1/1/80000002/0", out_valid_o, out_adel_o, out_pc_o, out_instr_o); end
        tick();
        #2;
        n_checks++; if (inst_req_o !== 1'b0 || out_valid_o !== 1'b0) begin n_errors++; $display("FAIL adel_park got=%b/%b exp=0/0", inst_req_o, out_valid_o); end
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80000010;
        tick();
        #2;
        n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h80000010) begin n_errors++; $display("FAIL adel_exit got=%b/%h exp=1/80000010", inst_req_o, inst_addr_o); end
`else
        n_checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h80000000) begin n_errors++; $display("FAIL align_addr got=%b/%h exp=1/80000000", inst_req_o, inst_addr_o); end
        inst_addr_ok_i = 1'b1;
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h66660000;
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b1 || out_adel_o !== 1'b0 || out_instr_o !== 32'h66660000) begin n_errors++; $display("FAIL align_out got=%b/%b/%h exp=1/0/66660000", out_valid_o, out_adel_o, out_instr_o); end
        n_checks++; if (inst_addr_o !== 32'h80000004) begin n_errors++; $display("FAIL align_next got=%h exp=80000004", inst_addr_o); end
`endif
    endtask

    // Reset during WAIT; a stray data_ok after release is ignored.
    task automatic test_reset_wait();
        inst_addr_ok_i = 1'b1;
        tick();
        #2;
        n_checks++; if (inst_req_o !== 1'b0) begin n_errors++; $display("FAIL rwt_wait got=%b exp=0", inst_req_o); end
        reset_i = 1'b1; #1;
        n_checks++; if (out_valid_o !== 1'b0 || inst_addr_o !== 32'hBFC00000 || inst_req_o !== 1'b1) begin n_errors++; $display("FAIL rwt_async got=%b/%h/%b exp=0/bfc00000/1", out_valid_o, inst_addr_o, inst_req_o); end
        tick();
        reset_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBEEFBEEF; #2;
        n_checks++; if (inst_addr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL rwt_addr got=%h exp=bfc00000", inst_addr_o); end
        tick();
        #2;
        n_checks++; if (out_valid_o !== 1'b0 || inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL rwt_late got=%b/%b/%h exp=0/1/bfc00000", out_valid_o, inst_req_o, inst_addr_o); end
    endtask

    initial begin
        test_reset();
        test_sequential_stall();
        test_redirect_wait();
        test_addr_hold();
        test_redirect_races();
        test_hold_redirect();
        test_wrap();
        test_misaligned();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
